// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
//   arb_state_t : arbiter FSM state
//   ALU_*       : ALUControl encodings ([3]=logic op, [0]=subtract / logic select)
//   NZCV_*      : bit positions inside a 4-bit NZCV flag vector
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Arithmetic: [3]=0, [0] selects subtract, [2:1] ignored.
    // Logic: [3]=1, [1:0] selects AND/OR/XOR/BIC, [2] inverts the result.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_BIC = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1101;

    localparam int ALU_LOGIC_BIT = 3;
    localparam int ALU_INV_BIT   = 2;
    localparam int ALU_SUB_BIT   = 0;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
//   req_*  : per-requester request channel (valid/ready, operands, control, setflags)
//   rsp_*  : per-requester response valid/ready plus shared result/NZCV bus
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][N-1:0]  req_a;
    logic [NREQ-1:0][N-1:0]  req_b;
    logic [NREQ-1:0][3:0]    req_ctrl;
    logic [NREQ-1:0]         req_setflags;
    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [N-1:0]            rsp_result;
    logic [3:0]              rsp_nzcv;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, req_setflags, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_nzcv
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, req_setflags, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_nzcv
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational N-bit ALU with NZCV flags.
//   a, b        : operands
//   alu_control : operation select (see alu_pkg encodings)
//   result      : N-bit result, no width extension
//   nzcv        : {negative, zero, carry-out, signed overflow}; C=V=0 for logic ops
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   alu_control,
    output logic [N-1:0] result,
    output logic [3:0]   nzcv
);
    logic         sub;
    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic [N-1:0] logic_raw;
    logic [N-1:0] logic_res;
    logic         carry;
    logic         overflow;

    always_comb begin
        sub   = alu_control[ALU_SUB_BIT];
        // Subtract as a + ~b + 1 so carry-out means "no borrow".
        b_eff = sub ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

        case (alu_control[1:0])
            2'b00:   logic_raw = a & b;
            2'b01:   logic_raw = a | b;
            2'b10:   logic_raw = a ^ b;
            default: logic_raw = a & ~b;
        endcase
        logic_res = alu_control[ALU_INV_BIT] ? ~logic_raw : logic_raw;

        if (alu_control[ALU_LOGIC_BIT]) begin
            result   = logic_res;
            carry    = 1'b0;
            overflow = 1'b0;
        end else begin
            result   = sum[N-1:0];
            carry    = sum[N];
            // Overflow when effective operand signs agree but the sum sign differs.
            overflow = ~(a[N-1] ^ b[N-1] ^ sub) & (a[N-1] ^ sum[N-1]);
        end

        nzcv         = '0;
        nzcv[NZCV_N] = result[N-1];
        nzcv[NZCV_Z] = ~|result;
        nzcv[NZCV_C] = carry;
        nzcv[NZCV_V] = overflow;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin grant and a single
// operation in flight. Accept at cycle t, response valid at t+2.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if slave modport (request/response channels)
//   flags_q    : per-requester NZCV registers, written on response handshake
//                when the op was issued with setflags
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_arbiter_if.slave          bus,
    output logic [NREQ-1:0][3:0]  flags_q
);
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   ctrl;
        logic         setflags;
        logic         gnt;
    } op_t;

    arb_state_t     state_q, state_d;
    op_t            op_q;
    logic           last_grant;
    logic [N-1:0]   rsp_result_q;
    logic [3:0]     rsp_nzcv_q;

    logic            pick_any, pick_idx;
    logic            grant, rsp_load, flag_we;
    logic [NREQ-1:0] req_ready, rsp_valid;
    logic [N-1:0]    alu_result;
    logic [3:0]      alu_nzcv;

    // The single shared ALU always looks at the latched op.
    alu_arbiter_alu #(.N(N)) u_alu (
        .a           (op_q.a),
        .b           (op_q.b),
        .alu_control (op_q.ctrl),
        .result      (alu_result),
        .nzcv        (alu_nzcv)
    );

    // Round-robin pick: on contention the requester not granted last time wins.
    always_comb begin
        pick_any = |bus.req_valid;
        pick_idx = 1'b0;
        if (bus.req_valid[0] && bus.req_valid[1]) pick_idx = ~last_grant;
        else if (bus.req_valid[1])                pick_idx = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        grant     = 1'b0;
        rsp_load  = 1'b0;
        flag_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready[pick_idx] = 1'b1;
                    grant               = 1'b1;
                    state_d             = EXEC;
                end
            end
            EXEC: begin
                rsp_load = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[op_q.gnt] = 1'b1;
                if (bus.rsp_ready[op_q.gnt]) begin
                    flag_we = op_q.setflags;
                    // Back-to-back: next op is accepted in the handshake cycle.
                    if (pick_any) begin
                        req_ready[pick_idx] = 1'b1;
                        grant               = 1'b1;
                        state_d             = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            last_grant   <= 1'b1;
            rsp_result_q <= '0;
            rsp_nzcv_q   <= '0;
            flags_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                op_q.a        <= bus.req_a[pick_idx];
                op_q.b        <= bus.req_b[pick_idx];
                op_q.ctrl     <= bus.req_ctrl[pick_idx];
                op_q.setflags <= bus.req_setflags[pick_idx];
                op_q.gnt      <= pick_idx;
                last_grant    <= pick_idx;
            end
            if (rsp_load) begin
                rsp_result_q <= alu_result;
                rsp_nzcv_q   <= alu_nzcv;
            end
            // op_q.gnt still names the completing op here even if a new grant
            // lands in the same cycle (op_q updates at this same edge).
            if (flag_we) flags_q[op_q.gnt] <= rsp_nzcv_q;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_nzcv   = rsp_nzcv_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a driver feeds per-requester stimulus
// queues, a negedge monitor predicts grants/responses/flags from a behavioural
// model and compares against the DUT.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam logic [3:0] OPS [7] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_BIC, ALU_NOR};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        sf;
    } stim_t;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic        sf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0][3:0] flags_q;

    alu_arbiter_if #(.N(N), .NREQ(2)) bus();

    alu_arbiter #(.N(N), .NREQ(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .flags_q (flags_q)
    );

    always #5 clk = ~clk;

    stim_t sq0[$];
    stim_t sq1[$];
    exp_t  sb[$];
    int    grant_log[$];
    int    tests = 0;
    int    fails = 0;
    int    cycle = 0;
    logic  acc_flag0 = 1'b0;
    logic  acc_flag1 = 1'b0;
    logic [1:0][3:0] mflags = '0;
    int    mlast = 1;
    int    rdy_mode = 0;
    logic [1:0] rdy_force = 2'b11;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cycle);
    endtask

    // Reference ALU computed from the arithmetic meaning of each op.
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
        logic [31:0] r;
        logic        c, v;
        longint      ua, ub, sa, sb_, sr;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                ua = ua + ub; r = ua[31:0]; c = ua[32];
                sr = sa + sb_; v = (sr > SMAX) || (sr < SMIN);
            end
            ALU_SUB: begin
                r = a - b; c = (a >= b);
                sr = sa - sb_; v = (sr > SMAX) || (sr < SMIN);
            end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_BIC: r = a & ~b;
            ALU_NOR: r = ~(a | b);
            default: r = 'x;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic push_stim(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] ctrl, input logic sf);
        stim_t s;
        s.a = a; s.b = b; s.ctrl = ctrl; s.sf = sf;
        if (i == 0) sq0.push_back(s);
        else        sq1.push_back(s);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Driver: present queue heads, retire items the monitor saw accepted.
    initial begin
        bus.req_valid    = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_ctrl     = '0;
        bus.req_setflags = '0;
        bus.rsp_ready    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_flag0) begin void'(sq0.pop_front()); acc_flag0 = 1'b0; end
            if (acc_flag1) begin void'(sq1.pop_front()); acc_flag1 = 1'b0; end
            if (sq0.size() > 0) begin
                bus.req_valid[0] = 1'b1; bus.req_a[0] = sq0[0].a; bus.req_b[0] = sq0[0].b;
                bus.req_ctrl[0] = sq0[0].ctrl; bus.req_setflags[0] = sq0[0].sf;
            end else bus.req_valid[0] = 1'b0;
            if (sq1.size() > 0) begin
                bus.req_valid[1] = 1'b1; bus.req_a[1] = sq1[0].a; bus.req_b[1] = sq1[0].b;
                bus.req_ctrl[1] = sq1[0].ctrl; bus.req_setflags[1] = sq1[0].sf;
            end else bus.req_valid[1] = 1'b0;
            if (rdy_mode == 1) begin
                bus.rsp_ready[0] = ($urandom_range(0, 9) < 7);
                bus.rsp_ready[1] = ($urandom_range(0, 9) < 7);
            end else bus.rsp_ready = rdy_force;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin : mon
            exp_t        e;
            logic [35:0] m;
            logic [1:0]  exp_v, exp_r;
            int          gi;
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_nzcv, flags_q}, 64'h0);
                sb.delete();
                mflags = '0;
                mlast = 1;
                acc_flag0 = 1'b0;
                acc_flag1 = 1'b0;
            end else begin
                check("flags_q", flags_q, mflags);
                if (sb.size() > 0) begin
                    e = sb[0];
                    exp_v = (cycle >= e.acc + 2) ? 2'(1 << e.idx) : 2'b00;
                    check("rsp_valid", bus.rsp_valid, exp_v);
                    if (exp_v != 2'b00) begin
                        check("rsp_result", bus.rsp_result, e.res);
                        check("rsp_nzcv", bus.rsp_nzcv, e.nzcv);
                        if (bus.rsp_ready[e.idx] && bus.rsp_valid == exp_v) begin
                            if (e.sf) mflags[e.idx] = e.nzcv;
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    check("rsp_valid_idle", bus.rsp_valid, 2'b00);
                end
                // A new op may only be accepted when nothing is left in flight.
                exp_r = 2'b00;
                if (sb.size() == 0) begin
                    if (bus.req_valid == 2'b11) exp_r = 2'(1 << (1 - mlast));
                    else                        exp_r = bus.req_valid;
                end
                check("req_ready", bus.req_ready, exp_r);
                if (exp_r != 2'b00 && bus.req_ready == exp_r) begin
                    gi = exp_r[1] ? 1 : 0;
                    m = ref_alu(bus.req_a[gi], bus.req_b[gi], bus.req_ctrl[gi]);
                    e.idx = gi; e.res = m[31:0]; e.nzcv = m[35:32];
                    e.sf = bus.req_setflags[gi]; e.acc = cycle;
                    sb.push_back(e);
                    mlast = gi;
                    grant_log.push_back(gi);
                    if (gi == 0) acc_flag0 = 1'b1; else acc_flag1 = 1'b1;
                end
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((sq0.size() != 0 || sq1.size() != 0 || sb.size() != 0) && n < 2000);
        if (n >= 2000) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rsp(input int i, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid[i] && n < 50);
        if (n >= 50) timeout_fail(name);
    endtask

    initial begin
        logic [1:0][3:0] saved;
        logic [31:0]     held_res;
        logic [3:0]      held_nzcv;
        int              n, pushed;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: signed overflow on ADD, flags for requester 0 only.
        push_stim(0, 32'h7FFF_FFFF, 32'h1, ALU_ADD, 1'b1);
        wait_rsp(0, "t1_rsp");
        check("t1_result", bus.rsp_result, 32'h8000_0000);
        check("t1_nzcv", bus.rsp_nzcv, 4'b1001);
        drain("t1_drain");
        check("t1_flags0", flags_q[0], 4'b1001);
        check("t1_flags1", flags_q[1], 4'b0000);

        // 2: equal SUB from requester 1.
        push_stim(1, 32'd5, 32'd5, ALU_SUB, 1'b1);
        wait_rsp(1, "t2_rsp");
        check("t2_result", bus.rsp_result, 32'h0);
        check("t2_nzcv", bus.rsp_nzcv, 4'b0110);
        drain("t2_drain");
        check("t2_flags", flags_q, {4'b0110, 4'b1001});

        // 3: both requesters continuously valid -> strict alternation.
        grant_log.delete();
        for (int k = 0; k < 3; k++) begin
            push_stim(0, rnd_operand(), rnd_operand(), ALU_ADD, 1'b0);
            push_stim(1, rnd_operand(), rnd_operand(), ALU_SUB, 1'b0);
        end
        drain("t3_drain");
        check("t3_grant_count", grant_log.size(), 6);
        for (int k = 0; k < grant_log.size() && k < 6; k++)
            check("t3_grant_order", grant_log[k], k % 2);

        // 4: stalled response holds the bus and blocks new grants.
        rdy_force = 2'b10;
        push_stim(0, 32'h1234_5678, 32'h0F0F_0F0F, ALU_XOR, 1'b1);
        push_stim(1, 32'h1, 32'h2, ALU_ADD, 1'b1);
        wait_rsp(0, "t4_rsp");
        held_res = bus.rsp_result;
        held_nzcv = bus.rsp_nzcv;
        check("t4_result", held_res, 32'h1D3B_5977);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_ready_blocked", bus.req_ready, 2'b00);
            check("t4_hold", {bus.rsp_valid, bus.rsp_nzcv, bus.rsp_result}, {2'b01, held_nzcv, held_res});
        end
        rdy_force = 2'b11;
        @(negedge clk);
        check("t4_regrant", bus.req_ready, 2'b10);
        drain("t4_drain");

        // 5: setflags=0 reports NZCV but leaves registers alone.
        saved = flags_q;
        push_stim(0, 32'h0, 32'h1, ALU_SUB, 1'b0);
        wait_rsp(0, "t5_rsp");
        check("t5_nzcv", bus.rsp_nzcv, 4'b1000);
        drain("t5_drain");
        check("t5_flags_kept", flags_q, saved);

        // 6: reset while the op is executing.
        push_stim(1, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req_ready[1] && n < 50);
        if (n >= 50) timeout_fail("t6_accept");
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t6_reset_state", {bus.rsp_valid, bus.rsp_nzcv, bus.rsp_result, flags_q}, 64'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_flag_write", flags_q, 8'h00);
        grant_log.delete();
        push_stim(0, 32'd10, 32'd3, ALU_SUB, 1'b1);
        push_stim(1, 32'd7, 32'd7, ALU_AND, 1'b1);
        drain("t6_drain");
        check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Random traffic with random response back-pressure.
        rdy_mode = 1;
        pushed = 0;
        n = 0;
        while (pushed < 150 && n < 20000) begin
            int i;
            @(negedge clk);
            n++;
            if ($urandom_range(0, 3) != 0) begin
                i = $urandom_range(0, 1);
                if ((i == 0 ? sq0.size() : sq1.size()) < 2) begin
                    push_stim(i, rnd_operand(), rnd_operand(), OPS[$urandom_range(0, 6)],
                              1'($urandom_range(0, 1)));
                    pushed++;
                end
            end
        end
        if (n >= 20000) timeout_fail("rand_push");
        rdy_mode = 0;
        rdy_force = 2'b11;
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end
endmodule
